shift_unit_seq: RTL and testbench

//  Iterative multi-mode shifter for the ALU logic-operand group; generalises the logical-right shifter.

---
 rtl/shift_unit_seq_pkg.sv | 19 +
 rtl/shift_unit_seq_if.sv | 35 +++
 rtl/shift_unit_seq_step.sv | 53 +++++
 rtl/shift_unit_seq.sv | 147 ++++++++++++++
 tb/tb_shift_unit_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_unit_seq_pkg.sv
// Shared types for the iterative multi-mode shifter.
//   shift_op_t : shift mode encoding (LSL, LSR, ASR, ROR) as seen on the op port.
//   state_t    : controller states IDLE -> SHIFT -> DONE -> IDLE.
package shift_unit_seq_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle of the iterative shifter.
//   Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both high. The producer holds its payload stable while valid is high and
//   ready is low; valid never depends combinationally on ready.
//   Request side : in_valid, in_ready, op, data_in, shamt
//   Response side: out_valid, out_ready, data_out, zero, carry
// master = requester/consumer (e.g. operand mux + result register), slave = shifter.
interface shift_unit_seq_if #(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
);
  import shift_unit_seq_pkg::*;

  logic          in_valid;
  logic          in_ready;
  shift_op_t     op;
  logic [N-1:0]  data_in;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  data_out;
  logic          zero;
  logic          carry;

  modport master (
    output in_valid, op, data_in, shamt, out_ready,
    input  in_ready, out_valid, data_out, zero, carry
  );

  modport slave (
    input  in_valid, op, data_in, shamt, out_ready,
    output in_ready, out_valid, data_out, zero, carry
  );

endinterface

// File: rtl/shift_unit_seq_step.sv
// One combinational shift step of the iterative shifter.
//   op        : shift mode
//   data      : current working value (N bits)
//   k         : bits to shift this step, 0..STEP (k = 0 passes data through)
//   result    : data shifted by k according to op
//   carry_out : last bit shifted out in this step (only with SHIFT_CARRY_EN)
// Optional feature macro: SHIFT_CARRY_EN adds the carry_out port.
module shift_unit_seq_step
  import shift_unit_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  shift_op_t     op,
  input  logic [N-1:0]  data,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  result
`ifdef SHIFT_CARRY_EN
  ,
  output logic          carry_out
`endif
);

  // Each legal k is decoded to a constant shift so every index below is static.
  always_comb begin
    result = data;
    for (int j = 1; j <= STEP; j++) begin
      if (k == KW'(j)) begin
        case (op)
          SH_LSL:  result = data << j;
          SH_LSR:  result = data >> j;
          SH_ASR:  result = $unsigned($signed(data) >>> j);
          default: result = (data >> j) | (data << (N - j));
        endcase
      end
    end
  end

`ifdef SHIFT_CARRY_EN
  // Left shifts lose bits off the top, all other modes lose them off the
  // bottom; for ROR the lost bit is also the new MSB.
  always_comb begin
    carry_out = 1'b0;
    for (int j = 1; j <= STEP; j++) begin
      if (k == KW'(j)) begin
        carry_out = (op == SH_LSL) ? data[N-j] : data[j-1];
      end
    end
  end
`endif

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative multi-mode shifter (LSL/LSR/ASR/ROR) with zero/carry flags.
// Shifts at most STEP bits per cycle; accept-to-out_valid latency is
// max(1, ceil(eff/STEP)) cycles where eff = min(shamt, N) (ROR: shamt mod N).
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : slave side of shift_unit_seq_if (request, response, flags)
//   dbg_state : current controller state
// Optional feature macro: SHIFT_CARRY_EN. When undefined, carry is tied to 0.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_unit_seq_if.slave     bus,
  output state_t              dbg_state
);

  localparam int SW = $clog2(N) + 1;
  localparam int KW = $clog2(STEP + 1);
  localparam logic [SW-1:0] N_SW    = SW'(N);
  localparam logic [SW-1:0] STEP_SW = SW'(STEP);

  state_t        state;
  shift_op_t     op_q;
  logic [N-1:0]  work_q;
  logic [SW-1:0] rem_q;

  logic [SW-1:0] eff_amt;
  logic [SW-1:0] k_sw;
  logic [KW-1:0] k;
  logic [N-1:0]  step_res;

  // ROR by a multiple of N is the identity; the others saturate at N.
  always_comb begin
    if (bus.op == SH_ROR) begin
      eff_amt = bus.shamt % N_SW;
    end else begin
      eff_amt = (bus.shamt > N_SW) ? N_SW : bus.shamt;
    end
  end

  assign k_sw = (rem_q > STEP_SW) ? STEP_SW : rem_q;
  assign k    = k_sw[KW-1:0];

`ifdef SHIFT_CARRY_EN
  logic step_carry;
  logic carry_run_q;
  logic over_q;
  logic carry_now;
  logic carry_fin;

  // A k = 0 step shifts nothing out, so the running carry is kept.
  assign carry_now = (k_sw != '0) ? step_carry : carry_run_q;
  // Logical shifts past the width report no carry; ASR past the width
  // already leaves the sign bit as the last bit out.
  assign carry_fin = (((op_q == SH_LSL) || (op_q == SH_LSR)) && over_q) ? 1'b0 : carry_now;
`else
  assign bus.carry = 1'b0;
`endif

  shift_unit_seq_step #(
    .N    (N),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .op        (op_q),
    .data      (work_q),
    .k         (k),
    .result    (step_res)
`ifdef SHIFT_CARRY_EN
    ,
    .carry_out (step_carry)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= SH_LSL;
      work_q        <= '0;
      rem_q         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.zero      <= 1'b1;
`ifdef SHIFT_CARRY_EN
      bus.carry     <= 1'b0;
      carry_run_q   <= 1'b0;
      over_q        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            op_q         <= bus.op;
            work_q       <= bus.data_in;
            rem_q        <= eff_amt;
            bus.in_ready <= 1'b0;
            state        <= ST_SHIFT;
`ifdef SHIFT_CARRY_EN
            carry_run_q  <= 1'b0;
            over_q       <= (bus.shamt > N_SW);
`endif
          end
        end

        ST_SHIFT: begin
          work_q <= step_res;
          rem_q  <= rem_q - k_sw;
`ifdef SHIFT_CARRY_EN
          carry_run_q <= carry_now;
`endif
          // This step consumes whatever remains: publish the result.
          if (rem_q == k_sw) begin
            state         <= ST_DONE;
            bus.out_valid <= 1'b1;
            bus.data_out  <= step_res;
            bus.zero      <= (step_res == '0);
`ifdef SHIFT_CARRY_EN
            bus.carry     <= carry_fin;
`endif
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state         <= ST_IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;
  import shift_unit_seq_pkg::*;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int SW   = $clog2(N) + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_seq_if #(.N(N), .SW(SW)) bus ();
  state_t dbg_state;

  shift_unit_seq #(.N(N), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [N+1:0] exp_q[$];   // {data, zero, carry}
  int           lat_q[$];
  int           acc_q[$];
  int           total = 0;
  int           bad   = 0;
  int           last_acc = 0;
  int           hs_cyc = 0;
  bit           bp_en = 1'b0;
  int           hold_cnt = 0;
  bit           seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {data, carry}; computed with wide shifts of padded vectors.
  function automatic logic [N:0] model(input shift_op_t op, input logic [N-1:0] d,
                                       input logic [SW-1:0] sh);
    int             eff;
    logic [2*N-1:0] w;
    logic [3*N-1:0] x;
    logic [N-1:0]   r;
    logic           c;
    bit             over;
    over = (int'(sh) > N);
    eff  = over ? N : int'(sh);
    case (op)
      SH_LSL: begin
        w = {{N{1'b0}}, d} << eff;
        r = w[N-1:0];
        c = (eff == 0 || over) ? 1'b0 : w[N];
      end
      SH_LSR: begin
        w = {d, {N{1'b0}}} >> eff;
        r = w[2*N-1:N];
        c = over ? 1'b0 : w[N-1];
      end
      SH_ASR: begin
        x = {{N{d[N-1]}}, d, {N{1'b0}}} >> eff;
        r = x[2*N-1:N];
        c = x[N-1];
      end
      default: begin
        eff = int'(sh) % N;
        w   = {d, d} >> eff;
        r   = w[N-1:0];
        c   = (eff != 0) ? r[N-1] : 1'b0;
      end
    endcase
`ifndef SHIFT_CARRY_EN
    c = 1'b0;
`endif
    return {r, c};
  endfunction

  function automatic int lat_of(input shift_op_t op, input logic [SW-1:0] sh);
    int eff;
    if (op == SH_ROR) eff = int'(sh) % N;
    else              eff = (int'(sh) > N) ? N : int'(sh);
    return (eff == 0) ? 1 : (eff + STEP - 1) / STEP;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input shift_op_t op, input logic [N-1:0] d, input logic [SW-1:0] sh,
                      input bit keep_valid);
    logic [N:0] m;
    int         n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.data_in  = d;
    bus.shamt    = sh;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready %0b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m = model(op, d, sh);
    exp_q.push_back({m[N:1], (m[N:1] == '0), m[0]});
    lat_q.push_back(lat_of(op, sh));
    acc_q.push_back(cyc);
    last_acc = cyc;
    // Operands need not be held after accept: scramble them.
    bus.in_valid = keep_valid;
    bus.op       = shift_op_t'($urandom_range(0, 3));
    bus.data_in  = N'($urandom_range(0, (1 << N) - 1));
    bus.shamt    = SW'($urandom_range(0, (1 << SW) - 1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [N+1:0] e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.out_ready = 1'b0;
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got out_valid 1 want 0 (data %0h)", bus.data_out);
          bus.out_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1'b1;
            check("latency", cyc - acc_q[0], lat_q[0]);
          end
          check("data_out", bus.data_out, e[N+1:2]);
          check("zero", bus.zero, e[1]);
          check("carry", bus.carry, e[0]);
          check("in_ready_busy", bus.in_ready, 1'b0);
          if (hold_cnt > 0) begin
            bus.out_ready = 1'b0;
            hold_cnt--;
          end else begin
            bus.out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            seen   = 1'b0;
            hs_cyc = cyc + 1;
          end
        end
      end else begin
        bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int first_hs;
    bus.in_valid = 1'b0;
    bus.op       = SH_LSL;
    bus.data_in  = '0;
    bus.shamt    = '0;

    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_carry", bus.carry, 1'b0);
    rst_n = 1'b1;

    // Directed corner cases.
    send(SH_LSR, 8'hB4, 4'd3,  1'b0);
    send(SH_ASR, 8'h96, 4'd2,  1'b0);
    send(SH_LSL, 8'h0F, 4'd10, 1'b0);
    send(SH_LSL, 8'h5A, 4'd0,  1'b0);
    send(SH_LSR, 8'h5A, 4'd0,  1'b0);
    send(SH_ASR, 8'h5A, 4'd0,  1'b0);
    send(SH_ROR, 8'h5A, 4'd0,  1'b0);
    send(SH_ASR, 8'h96, 4'd12, 1'b0);
    send(SH_ASR, 8'h7F, 4'd9,  1'b0);
    send(SH_LSR, 8'h80, 4'd8,  1'b0);
    send(SH_LSL, 8'h01, 4'd8,  1'b0);
    send(SH_ROR, 8'h81, 4'd8,  1'b0);
    send(SH_ROR, 8'h81, 4'd9,  1'b0);
    wait_drain();

    // Reset in the middle of a shift aborts it.
    send(SH_LSL, 8'h0F, 4'd10, 1'b0);
    @(negedge clk);
    check("pre_rst_state", dbg_state, ST_SHIFT);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_data_out", bus.data_out, 0);
    check("mid_rst_zero", bus.zero, 1'b1);
    check("mid_rst_carry", bus.carry, 1'b0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Backpressure: first result held for 3 cycles while a second request waits.
    hold_cnt = 3;
    send(SH_LSR, 8'hB4, 4'd3, 1'b1);
    send(SH_ROR, 8'h3C, 4'd5, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held: second accept one cycle after handshake.
    send(SH_ASR, 8'hC3, 4'd4, 1'b1);
    send(SH_LSL, 8'h33, 4'd1, 1'b0);
    first_hs = hs_cyc;
    check("b2b_gap", last_acc - first_hs, 1);
    wait_drain();

    // Randomized traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(shift_op_t'($urandom_range(0, 3)), N'($urandom_range(0, (1 << N) - 1)),
           SW'($urandom_range(0, (1 << SW) - 1)), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    wait_drain();
    bp_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
